adder_result_checker: RTL and testbench

- Self-checking response monitor; the consuming end of the counter-driven adder stimulus path.
- Samples the operands applied to a 4-bit adder, delays them to match the adder's pipeline latency, and recomputes {carry,sum}.
- Compares against the DUT outputs, counts vectors and mismatches, captures the first failing vector, and flags pass/fail at the end of a full operand sweep.
- Instantiated in adder benches alongside the stimulus counter, one instance per adder output pair (HH/HL/LH/LL).

---
 rtl/adder_result_checker.sv | 194 +++++++++++++++++++
 tb/tb_adder_result_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// -----------------------------------------------------------------------------
// adder_result_checker
//   Response monitor for a pipelined WIDTH-bit adder. The operands applied to
//   the adder are delayed by LATENCY cycles and the reference sum is recomputed
//   as a full WIDTH+1 bit {carry,sum}. The reference is compared against the
//   adder outputs. The block counts vectors and mismatches, captures the first
//   failing vector, and reports pass/fail once a full operand sweep completes.
//
// Parameters
//   WIDTH      operand / sum width
//   LATENCY    adder latency in clk cycles (0..7)
//   ERR_W      width of the saturating mismatch counter
//   SWEEP_LEN  number of vectors in one complete sweep
//
// Ports
//   clk        checker clock (same clock that advances the operands)
//   RST        synchronous active-low reset
//   valid_in   a/b hold a new vector this cycle
//   a, b       operands as applied to the adder
//   sum, c     adder outputs
//   busy       sweep in progress
//   done       sweep finished (sticky until reset)
//   pass       done with no mismatches
//   fail       at least one mismatch seen (sticky)
//   err_count  saturating mismatch count
//   vec_count  vectors compared so far
//   first_a/b  operands of the first mismatch
//   first_got  adder {c,sum} of the first mismatch
//
// Optional feature
//   ADDER_CHECKER_STOP_ON_ERR_EN: when defined, the first mismatch ends the
//   sweep. The FSM moves to DONE on the following cycle.
// -----------------------------------------------------------------------------
module adder_result_checker #(
  parameter int WIDTH     = 4,
  parameter int LATENCY   = 1,
  parameter int ERR_W     = 8,
  parameter int SWEEP_LEN = 2**(2*WIDTH)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   sum,
  input  logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   vec_count,
  output logic [WIDTH-1:0]   first_a,
  output logic [WIDTH-1:0]   first_b,
  output logic [WIDTH:0]     first_got
);

  localparam int VC_W = 2*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } vec_t;

  state_t state_q, state_d;

  // Delayed operand vector seen by the compare.
  vec_t dly;
  vec_t in_vec;
  assign in_vec = '{vld: valid_in, a: a, b: b};

  generate
    if (LATENCY == 0) begin : g_nodly
      assign dly = in_vec;
    end else begin : g_dly
      vec_t [LATENCY-1:0] vld_pipe_q;
      // Only the valid bits need a reset. The data bits are don't-care
      // when their valid bit is low.
      always_ff @(posedge clk) begin
        if (!RST) begin
          for (int i = 0; i < LATENCY; i++) vld_pipe_q[i].vld <= 1'b0;
        end else begin
          vld_pipe_q[0] <= in_vec;
          for (int i = 1; i < LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
      assign dly = vld_pipe_q[LATENCY-1];
    end
  endgenerate

  // Reference result and compare.
  logic [WIDTH:0] expected, got;
  logic           mismatch, cmp_en, last_cmp, stop_err;

  assign expected = {1'b0, dly.a} + {1'b0, dly.b};
  assign got      = {c, sum};
  assign mismatch = (got != expected);

  // At zero latency the sweep-opening vector is compared in the same cycle
  // that it moves the FSM out of IDLE. At LATENCY>0 the delay line is still
  // empty while in IDLE.
  assign cmp_en   = dly.vld && ((state_q == RUN) || ((LATENCY == 0) && (state_q == IDLE)));
  assign last_cmp = cmp_en && (vec_count_q == VC_W'(SWEEP_LEN - 1));

`ifdef ADDER_CHECKER_STOP_ON_ERR_EN
  assign stop_err = cmp_en && mismatch;
`else
  assign stop_err = 1'b0;
`endif

  // Counters and capture registers.
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [VC_W-1:0]  vec_count_q, vec_count_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] first_a_q, first_a_d, first_b_q, first_b_d;
  logic [WIDTH:0]   first_got_q, first_got_d;

  always_comb begin
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    fail_d      = fail_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_got_d = first_got_q;
    if (cmp_en) begin
      vec_count_d = vec_count_q + 1'b1;
      if (mismatch) begin
        fail_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        if (err_count_q == '0) begin
          first_a_d   = dly.a;
          first_b_d   = dly.b;
          first_got_d = got;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      err_count_q <= '0;
      vec_count_q <= '0;
      fail_q      <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_got_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      fail_q      <= fail_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_got_q <= first_got_d;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state. DONE holds until reset. Late vectors still in the
  // delay line are never compared.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (last_cmp || stop_err) state_d = DONE;
               else if (valid_in)        state_d = RUN;
      RUN:     if (last_cmp || stop_err) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. fail_q updates on the same edge that enters DONE, so pass
  // already reflects a mismatch on the final vector.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    pass = (state_q == DONE) && !fail_q;
  end

  assign fail      = fail_q;
  assign err_count = err_count_q;
  assign vec_count = vec_count_q;
  assign first_a   = first_a_q;
  assign first_b   = first_b_q;
  assign first_got = first_got_q;

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] a = '0, b = '0, sum;
  logic       c;
  logic       busy, done, pass, fail;
  logic [7:0] err_count;
  logic [8:0] vec_count;
  logic [3:0] first_a, first_b;
  logic [4:0] first_got;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(4), .LATENCY(1), .ERR_W(8)) dut (
    .clk(clk), .RST(RST), .valid_in(valid_in), .a(a), .b(b), .sum(sum), .c(c),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err_count),
    .vec_count(vec_count), .first_a(first_a), .first_b(first_b), .first_got(first_got)
  );

  // Behavioural adder under test, one cycle latency, with selectable faults:
  //   0 ideal, 1 wrong at 3+5, 2 every output inverted, 3 carry lost at F+F.
  function automatic logic [4:0] adder_out(input logic [3:0] x, input logic [3:0] y, input int m);
    logic [4:0] r;
    r = {1'b0, x} + {1'b0, y};
    case (m)
      1: if (x == 4'h3 && y == 4'h5) r = 5'h09;
      2: r = ~r;
      3: if (x == 4'hF && y == 4'hF) r = 5'h0E;
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk) {c, sum} <= adder_out(a, b, mode);

  task automatic chk(input string nm, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: one expected mismatch flag per pushed vector. Each one is
  // consumed when the checker reports another compared vector.
  bit         exp_q[$];
  int         model_err = 0;
  logic [8:0] prev_vc = '0;

  always @(posedge clk) begin
    #1;
    if (!RST) begin
      exp_q.delete();
      model_err = 0;
      prev_vc   = '0;
    end else if (vec_count != prev_vc) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: vec_count %0d with no pending vector", vec_count);
      end else if (exp_q.pop_front() && model_err < 255) begin
        model_err++;
      end
      chk("sb_vec", int'(vec_count), int'(prev_vc) + 1);
      chk("sb_err", int'(err_count), model_err);
      prev_vc = vec_count;
    end
  end

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input bit push);
    @(negedge clk);
    valid_in = 1'b1; a = x; b = y;
    n_vec++;
    if (push) exp_q.push_back(adder_out(x, y, mode) != ({1'b0, x} + {1'b0, y}));
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    RST = 1'b1;
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);      chk("rst_fail", fail, 0);
    chk("rst_err", err_count, 0);  chk("rst_vec", vec_count, 0);
    chk("rst_fa", first_a, 0);     chk("rst_fb", first_b, 0);
    chk("rst_fg", first_got, 0);
  endtask

  // Full sweep of a=i[7:4], b=i[3:0]. Optionally leave a one-cycle gap after
  // every gap-th vector. Vectors driven after the 256th are not pushed,
  // because the checker must discard them.
  task automatic run_sweep(input int m, input int gap);
    logic [7:0] v;
    mode = m;
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      drive(v[7:4], v[3:0], 1'b1);
      if (i == 128) chk("mid_busy", busy, 1);
      if (gap > 0 && i < 255 && (i % gap) == gap - 1) idle_cyc();
    end
    drive(4'h0, 4'h0, 1'b0);
    chk("done_early", done, 0);
    drive(4'h1, 4'h1, 1'b0);
    chk("done_lat", done, 1);
    drive(4'h2, 4'h2, 1'b0);
    idle_cyc();
    idle_cyc();
  endtask

  typedef struct {
    int         mode;
    int         gap;
    bit         pass;
    bit         fail;
    int         err;
    int         vec;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [4:0] fg;
  } rec_t;

  rec_t tbl[5];

  initial begin
    tbl[0] = '{mode: 0, gap: 0, pass: 1, fail: 0, err: 0,   vec: 256, fa: 4'h0, fb: 4'h0, fg: 5'h00};
    tbl[1] = '{mode: 1, gap: 0, pass: 0, fail: 1, err: 1,   vec: 256, fa: 4'h3, fb: 4'h5, fg: 5'h09};
    tbl[2] = '{mode: 2, gap: 0, pass: 0, fail: 1, err: 255, vec: 256, fa: 4'h0, fb: 4'h0, fg: 5'h1F};
    tbl[3] = '{mode: 3, gap: 0, pass: 0, fail: 1, err: 1,   vec: 256, fa: 4'hF, fb: 4'hF, fg: 5'h0E};
    tbl[4] = '{mode: 0, gap: 3, pass: 1, fail: 0, err: 0,   vec: 256, fa: 4'h0, fb: 4'h0, fg: 5'h00};

    for (int k = 0; k < 5; k++) begin
      do_reset();
      run_sweep(tbl[k].mode, tbl[k].gap);
      chk($sformatf("t%0d_done", k), done, 1);
      chk($sformatf("t%0d_busy", k), busy, 0);
      chk($sformatf("t%0d_pass", k), pass, int'(tbl[k].pass));
      chk($sformatf("t%0d_fail", k), fail, int'(tbl[k].fail));
      chk($sformatf("t%0d_err", k), err_count, tbl[k].err);
      chk($sformatf("t%0d_vec", k), vec_count, tbl[k].vec);
      chk($sformatf("t%0d_fa", k), first_a, int'(tbl[k].fa));
      chk($sformatf("t%0d_fb", k), first_b, int'(tbl[k].fb));
      chk($sformatf("t%0d_fg", k), first_got, int'(tbl[k].fg));
    end

    // The fault at 3+5 is vector 53. Fail must already be set before the
    // sweep is aborted by reset after 100 vectors.
    do_reset();
    mode = 1;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] v;
      v = 8'(i);
      drive(v[7:4], v[3:0], 1'b1);
      if (i == 55) chk("fail_sticky", fail, 1);
    end
    idle_cyc();
    idle_cyc();
    chk("abort_vec", vec_count, 100);
    chk("abort_err", err_count, 1);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    do_reset();
    run_sweep(0, 0);
    chk("restart_pass", pass, 1);
    chk("restart_fail", fail, 0);
    chk("restart_vec", vec_count, 256);
    chk("restart_err", err_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
